// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a small FIFO, issues them one at
// a time through registered operand ports to an external combinational ALU,
// captures the 64-bit result one cycle later and hands it out over a
// valid/ready response port with divide-by-zero flagging and an op counter.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic [2:0]               cmd_sel,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [2:0]               alu_sel,
  input  logic [63:0]              alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [63:0]              rsp_data,
  output logic [2:0]               rsp_sel,
  output logic                     rsp_div0,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0]  SEL_DIV  = 3'b011;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic          push;
  logic          pop;
  logic          div0_now;

  assign fifo_count = count;
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  // The FSM only pops after checking occupancy, so the FIFO never underflows.
  assign pop        = (count != '0) &&
                      ((state == IDLE) || (state == RESP && rsp_ready));
  assign head       = mem[rd_ptr];
  assign div0_now   = (alu_sel == SEL_DIV) && (alu_b == '0);

  // Command storage: written on push, read combinationally at the head.
  // NOTE: the storage array has no reset; validity is tracked by count/pointers,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'{a: cmd_a, b: cmd_b, sel: cmd_sel};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue/capture/response FSM with all ALU and response outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sel   <= '0;
      rsp_div0  <= 1'b0;
      op_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // ALU has had a full cycle to settle on the registered operands.
          rsp_valid <= 1'b1;
          rsp_sel   <= alu_sel;
          rsp_div0  <= div0_now;
          rsp_data  <= div0_now ? '1 : alu_result;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count  <= op_count + 1'b1;
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_a   <= head.a;
              alu_b   <= head.b;
              alu_sel <= head.sel;
              state   <= EXEC;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU drives
// alu_result, stimulus pushes expected responses into a scoreboard queue and
// an independent monitor compares every accepted response in order.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  sel;
    logic        div0;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_a;
  logic [31:0]       cmd_b;
  logic [2:0]        cmd_sel;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [2:0]        alu_sel;
  logic [63:0]       alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_data;
  logic [2:0]        rsp_sel;
  logic              rsp_div0;
  logic [2:0]        fifo_count;
  logic [CNT_W-1:0]  op_count;

  int   n_vec  = 0;
  int   n_fail = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_sel    (cmd_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_sel    (rsp_sel),
    .rsp_div0   (rsp_div0),
    .fifo_count (fifo_count),
    .op_count   (op_count)
  );

  // External combinational ALU; a zero divisor yields a junk pattern that the
  // sequencer must replace with all ones.
  function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] sel);
    logic [63:0] a64;
    logic [63:0] b64;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    case (sel)
      3'd0:    return a64 + b64;
      3'd1:    return a64 - b64;
      3'd2:    return a64 * b64;
      3'd3:    return (b == 0) ? 64'h0BAD_0BAD_0BAD_0BAD : {32'd0, a / b};
      3'd4:    return {32'd0, a & b};
      3'd5:    return {32'd0, a | b};
      3'd6:    return {32'd0, a ^ b};
      default: return {32'd0, ~(a & b)};
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_sel);

  // Reference: the sequencer returns the ALU answer on the command operands,
  // except a zero divisor, which reports all ones and the div0 flag.
  function automatic rsp_t ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] sel);
    rsp_t r;
    r.sel  = sel;
    r.div0 = (sel == 3'd3) && (b == 0);
    r.data = r.div0 ? 64'hFFFF_FFFF_FFFF_FFFF : alu_model(a, b, sel);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one command and wait (bounded) for it to be accepted. Prolonged
  // stalls release rsp_ready so the pipeline can drain.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                      input logic [63:0] exp_data, input logic exp_div0);
    int waited;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
      if (waited > 4) rsp_ready = 1'b1;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back('{data: exp_data, sel: sel, div0: exp_div0});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push_rand();
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    rsp_t        r;
    a   = $urandom;
    b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
    sel = 3'($urandom_range(0, 7));
    r   = ref_rsp(a, b, sel);
    push(a, b, sel, r.data, r.div0);
  endtask

  task automatic wait_drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: checks op_count every cycle, stability while back-pressured, and
  // every accepted response against the head of the scoreboard.
  initial begin
    logic [CNT_W-1:0] exp_ops;
    logic             held;
    logic [63:0]      held_data;
    logic [4:0]       held_ctl;
    rsp_t             e;
    exp_ops = '0;
    held    = 1'b0;
    held_data = '0;
    held_ctl  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        exp_ops = '0;
        held    = 1'b0;
      end else begin
        check("op_count", 64'(op_count), 64'(exp_ops));
        if (held) begin
          check("hold_data", rsp_data, held_data);
          check("hold_ctl", 64'({rsp_valid, rsp_div0, rsp_sel}), 64'(held_ctl));
        end
        if (rsp_valid && exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else if (rsp_valid && rsp_ready) begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_sel", 64'(rsp_sel), 64'(e.sel));
          check("rsp_div0", 64'(rsp_div0), 64'(e.div0));
          exp_ops = exp_ops + 1'b1;
        end
        held      = rsp_valid && !rsp_ready;
        held_data = rsp_data;
        held_ctl  = {rsp_valid, rsp_div0, rsp_sel};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa;
    logic [31:0] sb;
    logic [2:0]  ssel;
    rsp_t        r;
    int          n;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // First add: response must appear exactly two edges after acceptance.
    rsp_ready = 1'b1;
    push(32'd3, 32'd5, 3'd0, 64'd8, 1'b0);
    check("lat_t0", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("lat_t1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("lat_t2", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    check("op_count_first", 64'(op_count), 64'd1);

    // Arithmetic corner cases.
    push(32'd3, 32'd5, 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 64'hFFFF_FFFE_0000_0001, 1'b0);
    push(32'd100, 32'd7, 3'd3, 64'd14, 1'b0);
    push(32'd100, 32'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_drain();

    // Fill: with responses blocked, five are accepted and the sixth stalls.
    rsp_ready = 1'b0;
    repeat (DEPTH + 1) push_rand();
    sa   = $urandom;
    sb   = $urandom;
    ssel = 3'd5;
    cmd_a     = sa;
    cmd_b     = sb;
    cmd_sel   = ssel;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_cmd_ready", 64'(cmd_ready), 64'd0);
      check("full_count", 64'(fifo_count), 64'(DEPTH));
    end
    rsp_ready = 1'b1;
    r = ref_rsp(sa, sb, ssel);
    push(sa, sb, ssel, r.data, r.div0);
    wait_drain();

    // Long backpressure on a single AND response.
    rsp_ready = 1'b0;
    push(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 64'h0000_0000_00F0_00F0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    repeat (10) @(negedge clk);
    wait_drain();

    // Reset while a command executes and two more are queued.
    rsp_ready = 1'b1;
    repeat (4) push_rand();
    check("pre_rst_count", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    #1;
    check("arst_alu", 64'({alu_a, alu_sel}), 64'd0);
    check("arst_alu_b", 64'(alu_b), 64'd0);
    check("arst_rsp", 64'({rsp_valid, rsp_div0, rsp_sel}), 64'd0);
    check("arst_rsp_data", rsp_data, 64'd0);
    check("arst_fifo_count", 64'(fifo_count), 64'd0);
    check("arst_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_idle", 64'(rsp_valid), 64'd0);

    push(32'hFFFF_0000, 32'h0F0F_0F0F, 3'd6, 64'h0000_0000_F0F0_0F0F, 1'b0);
    wait_drain();

    // Random traffic with random response backpressure.
    for (int i = 0; i < 60; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      push_rand();
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
